writeback_serializer: RTL and testbench
=======================================

Name: writeback_serializer

Overview:
- Sits directly downstream of the execute stage.
- Captures each completed vector result: ALU_NUM lanes of N-bit fixed point, the lane-enable mask, and the zero flag.
- Buffers results in a small FIFO, then streams the enabled lanes one per beat onto a single N-bit write port (valid/ready) toward the data memory / register file.
- Also keeps the last zero flag as a registered status for branch logic.

Parameters:
- N, 32, lane data width (Q16.16 fixed point, passed through unmodified).
- ALU_NUM, 24, number of lanes per vector result.
- DEPTH, 2, vector entries in the input FIFO (power of 2, >=2).
- ADDR_W, 16, write-address width.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  execute result valid.
- in_ready  out  1  entry free; a transfer occurs when in_valid && in_ready.
- in_mask  in  ALU_NUM  lanes to write (the enable_alu of the issuing op).
- in_zero  in  1  execute zero flag.
- in_data  in  ALU_NUM x N  signed lane results.
- in_base  in  ADDR_W  destination base address.
- wr_valid  out  1  beat valid.
- wr_ready  in  1  sink accepts beat.
- wr_addr  out  ADDR_W  in_base + lane index.
- wr_data  out  N  lane data.
- wr_last  out  1  final enabled lane of the entry.
- zero_flag  out  1  in_zero of the most recently accepted entry.
- busy  out  1  FIFO non-empty.

Behaviour:
- Reset (async, rstn=0):
  - FIFO empty; lane pointer = 0; state IDLE.
  - Outputs: wr_valid=0, wr_addr=0, wr_data=0, wr_last=0, zero_flag=0, busy=0, in_ready=1.
- Input side:
  - in_ready = !full. It is a function of registered count only; there is no combinational path from wr_ready.
  - When full, no entry is accepted, even in a cycle where the head retires.
  - On acceptance: store {in_mask, in_data, in_base} at the tail, and set zero_flag <= in_zero in the same edge.
- States:
  - IDLE: wr_valid=0. If the FIFO is non-empty at a clock edge, go to SEND, load ptr = lowest set bit of the head mask, and register wr_* from the head entry.
  - SEND: wr_valid=1.
    - wr_addr = head.base + ptr, truncated mod 2^ADDR_W (wrap, no error).
    - wr_data = head.data[ptr].
    - wr_last=1 iff no set mask bit above ptr.
  - Stall: while wr_valid && !wr_ready, all wr_* are held stable.
  - Beat accepted, not last: ptr jumps to the next set bit above ptr in one cycle. Disabled lanes cost zero bubbles.
  - Beat accepted, last: pop the head.
    - If the FIFO is still non-empty (including an entry accepted in that same cycle into a previously non-full FIFO), load the next head back-to-back with no idle cycle.
    - Otherwise go to IDLE.
- Empty mask: an entry with in_mask = 0 is retired in a single cycle with no beat (wr_valid stays 0) and no other side effect. zero_flag is still updated at acceptance.
- Latency: an entry accepted at edge k into an empty FIFO gives wr_valid=1 from edge k+1. Sustained throughput is one lane per cycle.
- Lane data is not modified, sign-extended or saturated.
- Reset mid-operation: the in-flight entry and all buffered entries are discarded; outputs return to reset values asynchronously.
- Entry count uses a log2(DEPTH)+1-bit counter. Full = count==DEPTH; empty = count==0. Pointers wrap mod DEPTH.

Decomposition:
- Shared package finder_pkg:
  - Constants N, Q, ALU_NUM.
  - typedef lane_t (signed N-bit).
  - typedef vec_t (ALU_NUM x lane_t).
  - typedef wb_entry_t struct {mask, data, base}.
- One sub-module, lane_picker: purely combinational. Given mask and ptr, it returns next_idx (lowest set bit strictly above ptr), first_idx (lowest set bit), has_next and any.
- FIFO storage and the FSM stay in writeback_serializer.

Test Plan:
- Reset, then one entry: mask=0x000005, base=0x0100, data[0]=0x00010000, data[2]=0xFFFF8000, wr_ready=1 -> beats (0x0100,0x00010000,last=0), (0x0102,0xFFFF8000,last=1) on consecutive cycles, then wr_valid=0.
- Back-to-back full masks (0xFFFFFF) x3, wr_ready=1 -> 72 contiguous beats with no gap. in_ready drops while 2 entries are held. wr_last pulses on beats 24, 48 and 72.
- Backpressure: mask=0x800001, wr_ready low 5 cycles on the first beat -> wr_addr/wr_data held constant. After release, second beat addr=base+23.
- Empty mask entry followed by mask=0x000002 -> no beat for the first entry; next beat addr=base+1 appears at most 2 cycles later. zero_flag follows each in_zero (1 then 0).
- Address wrap: base=0xFFFE, mask=0x00000F -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Assert rstn=0 mid-stream (beat 5 of 24) -> wr_valid=0 and busy=0 immediately. After release, in_ready=1 and no stale beats appear.

Source files
------------

// File: rtl/finder_pkg.sv
// Shared types and constants for the writeback path: lane format, vector
// result layout and the serializer state encoding.
package finder_pkg;

    localparam int N       = 32;
    localparam int Q       = 16;
    localparam int ALU_NUM = 24;
    localparam int ADDR_W  = 16;

    typedef logic signed [N-1:0] lane_t;
    typedef lane_t [ALU_NUM-1:0] vec_t;

    typedef struct packed {
        logic [ALU_NUM-1:0] mask;
        vec_t               data;
        logic [ADDR_W-1:0]  base;
    } wb_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } wb_state_e;

endpackage

// File: rtl/lane_picker.sv
// Combinational lane search over a lane-enable mask: lowest enabled lane,
// and lowest enabled lane strictly above ptr.
module lane_picker
    import finder_pkg::*;
#(
    parameter int W  = ALU_NUM,
    parameter int IW = (ALU_NUM > 1) ? $clog2(ALU_NUM) : 1
) (
    input  logic [W-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] next_idx,
    output logic [IW-1:0] first_idx,
    output logic          has_next,
    output logic          any
);

    always_comb begin
        next_idx  = '0;
        first_idx = '0;
        has_next  = 1'b0;
        any       = 1'b0;
        // Scan downward so the final hit is the lowest qualifying lane.
        for (int unsigned i = W; i > 0; i--) begin
            if (mask[i-1]) begin
                first_idx = IW'(i - 1);
                any       = 1'b1;
                if ((i - 1) > 32'(ptr)) begin
                    next_idx = IW'(i - 1);
                    has_next = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/writeback_serializer.sv
// Buffers completed vector results in a small FIFO and streams their enabled
// lanes one per beat onto a single valid/ready write port.
module writeback_serializer
    import finder_pkg::*;
#(
    parameter int N       = 32,
    parameter int ALU_NUM = 24,
    parameter int DEPTH   = 2,
    parameter int ADDR_W  = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ALU_NUM-1:0]        in_mask,
    input  logic                      in_zero,
    input  logic [ALU_NUM-1:0][N-1:0] in_data,
    input  logic [ADDR_W-1:0]         in_base,
    output logic                      wr_valid,
    input  logic                      wr_ready,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [N-1:0]              wr_data,
    output logic                      wr_last,
    output logic                      zero_flag,
    output logic                      busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW = (ALU_NUM > 1) ? $clog2(ALU_NUM) : 1;
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C  = (AW+1)'(1);

    typedef struct packed {
        logic [ALU_NUM-1:0]        mask;
        logic [ALU_NUM-1:0][N-1:0] data;
        logic [ADDR_W-1:0]         base;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop;

    wb_state_e     state, state_next;
    logic [IW-1:0] ptr, ptr_next;

    logic [ALU_NUM-1:0] next_mask;
    logic               next_avail;
    logic [IW-1:0]      h_first, h_next, n_first, unused_n_next;
    logic               h_any, h_has_next, n_any, unused_n_has_next;

    assign full     = (count == FULL_C);
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign busy     = !empty;
    assign push     = in_valid && !full;
    assign head     = mem[rd_ptr];

    // With one entry left, the follower is whatever lands in the same edge,
    // so its mask is taken straight from the input to avoid an idle cycle.
    assign next_mask  = (count == ONE_C) ? in_mask : mem[rd_ptr + AW'(1)].mask;
    assign next_avail = (count > ONE_C) || push;

    lane_picker #(.W(ALU_NUM), .IW(IW)) u_head_pick (
        .mask      (head.mask),
        .ptr       (ptr),
        .next_idx  (h_next),
        .first_idx (h_first),
        .has_next  (h_has_next),
        .any       (h_any)
    );

    lane_picker #(.W(ALU_NUM), .IW(IW)) u_next_pick (
        .mask      (next_mask),
        .ptr       ('0),
        .next_idx  (unused_n_next),
        .first_idx (n_first),
        .has_next  (unused_n_has_next),
        .any       (n_any)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            zero_flag <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr    <= wr_ptr + AW'(1);
                zero_flag <= in_zero;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{mask: in_mask, data: in_data, base: in_base};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                if (!empty && h_any) begin
                    state_next = SEND;
                    ptr_next   = h_first;
                end
            end
            SEND: begin
                if (wr_ready) begin
                    if (h_has_next) begin
                        ptr_next = h_next;
                    end else if (next_avail && n_any) begin
                        ptr_next = n_first;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_last  = 1'b0;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                // An all-disabled entry retires here without producing a beat.
                pop = !empty && !h_any;
            end
            SEND: begin
                wr_valid = 1'b1;
                wr_addr  = head.base + ADDR_W'(ptr);
                wr_data  = head.data[ptr];
                wr_last  = !h_has_next;
                pop      = wr_ready && !h_has_next;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_writeback_serializer.sv
// Directed bench for writeback_serializer: single entry, back-to-back full
// masks, backpressure, empty mask, address wrap and reset mid-stream.
module tb_writeback_serializer;

    localparam int N       = 32;
    localparam int ALU_NUM = 24;
    localparam int DEPTH   = 2;
    localparam int ADDR_W  = 16;

    logic                      clk;
    logic                      rstn;
    logic                      in_valid;
    logic                      in_ready;
    logic [ALU_NUM-1:0]        in_mask;
    logic                      in_zero;
    logic [ALU_NUM-1:0][N-1:0] in_data;
    logic [ADDR_W-1:0]         in_base;
    logic                      wr_valid;
    logic                      wr_ready;
    logic [ADDR_W-1:0]         wr_addr;
    logic [N-1:0]              wr_data;
    logic                      wr_last;
    logic                      zero_flag;
    logic                      busy;

    int checks   = 0;
    int failures = 0;

    writeback_serializer #(
        .N       (N),
        .ALU_NUM (ALU_NUM),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .in_zero   (in_zero),
        .in_data   (in_data),
        .in_base   (in_base),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_last   (wr_last),
        .zero_flag (zero_flag),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        rstn = 1'b1; in_valid = 1'b0; in_mask = '0; in_zero = 1'b0;
        in_data = '0; in_base = '0; wr_ready = 1'b0;
        #2 rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({wr_valid, wr_last, zero_flag, busy, in_ready} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_flags: valid/last/zero/busy/in_ready=%b want 00001",
                     {wr_valid, wr_last, zero_flag, busy, in_ready});
        end
        checks++;
        if (wr_addr !== 16'h0000) begin
            failures++;
            $display("FAIL reset_addr: got %h want 0000", wr_addr);
        end
        checks++;
        if (wr_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: got %h want 00000000", wr_data);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        in_data = '0;
        in_data[0] = 32'h0001_0000;
        in_data[2] = 32'hFFFF_8000;
        in_valid = 1'b1; in_mask = 24'h000005; in_base = 16'h0100;
        in_zero = 1'b1; wr_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (wr_valid !== 1'b0 || busy !== 1'b1 || zero_flag !== 1'b1) begin
            failures++;
            $display("FAIL basic_accept: valid=%b busy=%b zero=%b want 0 1 1",
                     wr_valid, busy, zero_flag);
        end
        @(negedge clk);
        checks++;
        if (wr_valid !== 1'b1 || wr_addr !== 16'h0100 || wr_data !== 32'h0001_0000 || wr_last !== 1'b0) begin
            failures++;
            $display("FAIL basic_beat0: valid=%b addr=%h data=%h last=%b want 1 0100 00010000 0",
                     wr_valid, wr_addr, wr_data, wr_last);
        end
        @(negedge clk);
        checks++;
        if (wr_valid !== 1'b1 || wr_addr !== 16'h0102 || wr_data !== 32'hFFFF_8000 || wr_last !== 1'b1) begin
            failures++;
            $display("FAIL basic_beat1: valid=%b addr=%h data=%h last=%b want 1 0102 ffff8000 1",
                     wr_valid, wr_addr, wr_data, wr_last);
        end
        @(negedge clk);
        checks++;
        if (wr_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done: valid=%b busy=%b want 0 0", wr_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        int nb, gaps, w;
        bit started, saw_full, timed_out;
        logic [ADDR_W-1:0] ea;
        logic [N-1:0]      ed;
        logic              el;
        nb = 0; gaps = 0; w = 0;
        started = 1'b0; saw_full = 1'b0; timed_out = 1'b0;
        wr_ready = 1'b1;
        fork
            begin
                for (int e = 0; e < 3; e++) begin
                    in_valid = 1'b1;
                    in_mask  = '1;
                    in_base  = 16'h1000 + 16'(e * 256);
                    in_zero  = (e == 1);
                    for (int i = 0; i < ALU_NUM; i++)
                        in_data[i] = 32'hC000_0000 | 32'(e << 16) | 32'(i);
                    w = 0;
                    while (!in_ready && w < 100) begin
                        saw_full = 1'b1;
                        @(negedge clk);
                        w++;
                    end
                    if (w >= 100) timed_out = 1'b1;
                    @(negedge clk);
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 200 && nb < 72; c++) begin
                    @(negedge clk);
                    if (wr_valid) begin
                        started = 1'b1;
                        ea = 16'h1000 + 16'((nb / 24) * 256 + (nb % 24));
                        ed = 32'hC000_0000 | 32'((nb / 24) << 16) | 32'(nb % 24);
                        el = ((nb % 24) == 23);
                        checks++;
                        if (wr_addr !== ea || wr_data !== ed || wr_last !== el) begin
                            failures++;
                            $display("FAIL b2b_beat%0d: addr=%h data=%h last=%b want %h %h %b",
                                     nb, wr_addr, wr_data, wr_last, ea, ed, el);
                        end
                        nb++;
                    end else if (started) begin
                        gaps++;
                    end
                end
            end
        join
        checks++;
        if (nb != 72) begin
            failures++;
            $display("FAIL b2b_count: got %0d beats want 72", nb);
        end
        checks++;
        if (gaps != 0) begin
            failures++;
            $display("FAIL b2b_gaps: got %0d idle cycles want 0", gaps);
        end
        checks++;
        if (saw_full !== 1'b1 || timed_out !== 1'b0) begin
            failures++;
            $display("FAIL b2b_in_ready: saw_full=%b timed_out=%b want 1 0", saw_full, timed_out);
        end
        @(negedge clk);
        checks++;
        if (wr_valid !== 1'b0 || busy !== 1'b0 || zero_flag !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done: valid=%b busy=%b zero=%b want 0 0 0", wr_valid, busy, zero_flag);
        end
    endtask

    task automatic test_backpressure();
        in_data = '0;
        in_data[0]  = 32'h1234_5678;
        in_data[23] = 32'h8765_4321;
        in_valid = 1'b1; in_mask = 24'h800001; in_base = 16'h2000;
        in_zero = 1'b0; wr_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (wr_valid !== 1'b1 || wr_addr !== 16'h2000 || wr_data !== 32'h1234_5678 || wr_last !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d: valid=%b addr=%h data=%h last=%b want 1 2000 12345678 0",
                         c, wr_valid, wr_addr, wr_data, wr_last);
            end
            if (c == 4) wr_ready = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (wr_valid !== 1'b1 || wr_addr !== 16'h2017 || wr_data !== 32'h8765_4321 || wr_last !== 1'b1) begin
            failures++;
            $display("FAIL bp_beat1: valid=%b addr=%h data=%h last=%b want 1 2017 87654321 1",
                     wr_valid, wr_addr, wr_data, wr_last);
        end
        @(negedge clk);
        checks++;
        if (wr_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_done: valid=%b busy=%b want 0 0", wr_valid, busy);
        end
    endtask

    task automatic test_empty_mask();
        wr_ready = 1'b1;
        in_data = '0;
        in_valid = 1'b1; in_mask = 24'h000000; in_base = 16'h3000; in_zero = 1'b1;
        @(negedge clk);
        checks++;
        if (zero_flag !== 1'b1) begin
            failures++;
            $display("FAIL empty_zero1: got %b want 1", zero_flag);
        end
        in_mask = 24'h000002; in_zero = 1'b0;
        in_data[1] = 32'h0BAD_F00D;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (zero_flag !== 1'b0 || wr_valid !== 1'b0) begin
            failures++;
            $display("FAIL empty_nobeat: zero=%b valid=%b want 0 0", zero_flag, wr_valid);
        end
        @(negedge clk);
        checks++;
        if (wr_valid !== 1'b1 || wr_addr !== 16'h3001 || wr_data !== 32'h0BAD_F00D || wr_last !== 1'b1) begin
            failures++;
            $display("FAIL empty_next: valid=%b addr=%h data=%h last=%b want 1 3001 0badf00d 1",
                     wr_valid, wr_addr, wr_data, wr_last);
        end
        @(negedge clk);
        checks++;
        if (wr_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL empty_done: valid=%b busy=%b want 0 0", wr_valid, busy);
        end
    endtask

    task automatic test_addr_wrap();
        logic [ADDR_W-1:0] exp_a [4];
        int nb;
        exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
        nb = 0;
        wr_ready = 1'b1;
        for (int i = 0; i < ALU_NUM; i++) in_data[i] = 32'h5000_0000 + 32'(i);
        in_valid = 1'b1; in_mask = 24'h00000F; in_base = 16'hFFFE; in_zero = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 10 && nb < 4; c++) begin
            @(negedge clk);
            if (wr_valid) begin
                checks++;
                if (wr_addr !== exp_a[nb] || wr_data !== 32'h5000_0000 + 32'(nb) || wr_last !== (nb == 3)) begin
                    failures++;
                    $display("FAIL wrap_beat%0d: addr=%h data=%h last=%b want %h %h %b",
                             nb, wr_addr, wr_data, wr_last, exp_a[nb], 32'h5000_0000 + 32'(nb), (nb == 3));
                end
                nb++;
            end
        end
        checks++;
        if (nb != 4) begin
            failures++;
            $display("FAIL wrap_count: got %0d beats want 4", nb);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int nb, w, stale;
        nb = 0; w = 0; stale = 0;
        wr_ready = 1'b1;
        for (int i = 0; i < ALU_NUM; i++) in_data[i] = 32'hD000_0000 + 32'(i);
        in_valid = 1'b1; in_mask = '1; in_base = 16'h4000; in_zero = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        while (nb < 5 && w < 50) begin
            @(negedge clk);
            w++;
            if (wr_valid) nb++;
        end
        checks++;
        if (nb != 5 || wr_addr !== 16'h4004) begin
            failures++;
            $display("FAIL midrst_reach: beats=%0d addr=%h want 5 4004", nb, wr_addr);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (wr_valid !== 1'b0 || busy !== 1'b0 || wr_addr !== 16'h0000 || wr_data !== 32'h0 || zero_flag !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async: valid=%b busy=%b addr=%h data=%h zero=%b want 0 0 0000 00000000 0",
                     wr_valid, busy, wr_addr, wr_data, zero_flag);
        end
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_ready: in_ready=%b busy=%b want 1 0", in_ready, busy);
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (wr_valid) stale++;
        end
        checks++;
        if (stale != 0) begin
            failures++;
            $display("FAIL midrst_stale: got %0d stale beats want 0", stale);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_empty_mask();
        test_addr_wrap();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
